axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/cl_arrow_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/axi_rd_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_arrow_arb_pkg.sv
// Shared AXI widths, default port count and AR state encoding for the
// read-channel arbiter and its round-robin core.
package cl_arrow_arb_pkg;

  localparam int AXI_ID_W   = 16;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;
  localparam int AXI_RESP_W = 2;

  localparam int DEFAULT_NUM_PORTS = 4;
  localparam int OSTD_CNT_W        = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_SIZE_W-1:0] size;
  } ar_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: search starts at the pointer, and the pointer
// moves to winner+1 only when the caller actually takes the grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             grant_en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!grant_vld && req[cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en && grant_vld) begin
      if ({1'b0, grant_idx} == N_W - 1'b1) ptr_d = '0;
      else                                  ptr_d = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI read arbiter: round-robin AR mux with a one-deep output register
// and ID-based R demux. Define AXI_RD_ARB_OSTD_LIMIT_EN for per-port outstanding limits.
//
//   state | meaning
//   IDLE  | output AR register empty, m_arvalid low
//   ISSUE | output AR register holds one request, m_arvalid high
module axi_rd_arbiter
  import cl_arrow_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int IDX_W     = $clog2(NUM_PORTS),
  parameter int MAX_OSTD  = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [AXI_ID_W-1:0]   s_arid    [NUM_PORTS],
  input  logic [AXI_ADDR_W-1:0] s_araddr  [NUM_PORTS],
  input  logic [AXI_LEN_W-1:0]  s_arlen   [NUM_PORTS],
  input  logic [AXI_SIZE_W-1:0] s_arsize  [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]  s_arvalid,
  output logic [NUM_PORTS-1:0]  s_arready,

  output logic [AXI_ID_W-1:0]   s_rid     [NUM_PORTS],
  output logic [AXI_DATA_W-1:0] s_rdata   [NUM_PORTS],
  output logic [AXI_RESP_W-1:0] s_rresp   [NUM_PORTS],
  output logic [NUM_PORTS-1:0]  s_rlast,
  output logic [NUM_PORTS-1:0]  s_rvalid,
  input  logic [NUM_PORTS-1:0]  s_rready,

  output logic [AXI_ID_W-1:0]   m_arid,
  output logic [AXI_ADDR_W-1:0] m_araddr,
  output logic [AXI_LEN_W-1:0]  m_arlen,
  output logic [AXI_SIZE_W-1:0] m_arsize,
  output logic                  m_arvalid,
  input  logic                  m_arready,

  input  logic [AXI_ID_W-1:0]   m_rid,
  input  logic [AXI_DATA_W-1:0] m_rdata,
  input  logic [AXI_RESP_W-1:0] m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || IDX_W < $clog2(NUM_PORTS) ||
      MAX_OSTD < 1 || MAX_OSTD > 255) begin : g_param_check
    $error("axi_rd_arbiter: parameter out of range");
  end

  ar_state_e            state_q, state_d;
  ar_req_t              ar_q, ar_d, sel_req;
  logic [NUM_PORTS-1:0] eligible, blocked, grant, r_hit;
  logic [IDX_W-1:0]     grant_idx, r_port;
  logic                 grant_vld, grant_en, load, r_port_ok;
  logic                 unused_arid_hi;

  // The output register may refill whenever it is empty or draining this cycle.
  assign grant_en = !reset && (state_q == IDLE || m_arready);
  assign eligible = s_arvalid & ~blocked;
  assign load     = grant_en && grant_vld;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .grant_en  (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign s_arready = load ? grant : '0;

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_req.id   = {grant_idx, s_arid[i][AXI_ID_W-IDX_W-1:0]};
        sel_req.addr = s_araddr[i];
        sel_req.len  = s_arlen[i];
        sel_req.size = s_arsize[i];
      end
    end
  end

  always_comb begin
    unused_arid_hi = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      unused_arid_hi = unused_arid_hi ^ (^s_arid[i][AXI_ID_W-1 -: IDX_W]);
  end

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = ISSUE;
          ar_d    = sel_req;
        end
      end
      ISSUE: begin
        if (m_arready) begin
          if (load) ar_d    = sel_req;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
    end
  end

  assign m_arvalid = (state_q == ISSUE);
  assign m_arid    = ar_q.id;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;

  // R demux: port index lives in the top ID bits; unknown indices are sunk.
  assign r_port    = m_rid[AXI_ID_W-1 -: IDX_W];
  assign r_port_ok = ({1'b0, r_port} < (IDX_W+1)'(NUM_PORTS));

  always_comb begin
    r_hit    = '0;
    m_rready = 1'b0;
    if (!reset) begin
      if (!r_port_ok) m_rready = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_port_ok && r_port == IDX_W'(i)) begin
          r_hit[i] = 1'b1;
          m_rready = s_rready[i];
        end
      end
    end
  end

  assign s_rvalid = r_hit & {NUM_PORTS{m_rvalid}};

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_rid[i]   = {{IDX_W{1'b0}}, m_rid[AXI_ID_W-IDX_W-1:0]};
      s_rdata[i] = m_rdata;
      s_rresp[i] = m_rresp;
      s_rlast[i] = m_rlast;
    end
  end

`ifdef AXI_RD_ARB_OSTD_LIMIT_EN
  localparam logic [OSTD_CNT_W-1:0] OSTD_MAX = OSTD_CNT_W'(MAX_OSTD);

  logic [OSTD_CNT_W-1:0] ostd_q [NUM_PORTS];
  logic [OSTD_CNT_W-1:0] ostd_d [NUM_PORTS];

  // Blocking uses the registered count so a same-cycle rlast frees a slot next cycle.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) blocked[i] = (ostd_q[i] == OSTD_MAX);
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      ostd_d[i] = ostd_q[i];
      case ({s_arvalid[i] && s_arready[i], s_rvalid[i] && s_rready[i] && m_rlast})
        2'b10:   ostd_d[i] = ostd_q[i] + 1'b1;
        2'b01:   ostd_d[i] = ostd_q[i] - 1'b1;
        default: ostd_d[i] = ostd_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) ostd_q[i] <= '0;
    end else begin
      ostd_q <= ostd_d;
    end
  end
`else
  assign blocked = '0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference (one held request, RR pointer, per-port counts).
module tb_axi_rd_arbiter;

  localparam int NP = 4;
`ifdef AXI_RD_ARB_OSTD_LIMIT_EN
  localparam int MO      = 2;
  localparam bit OSTD_ON = 1'b1;
`else
  localparam int MO      = 16;
  localparam bit OSTD_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]   s_arid   [NP];
  logic [63:0]   s_araddr [NP];
  logic [7:0]    s_arlen  [NP];
  logic [2:0]    s_arsize [NP];
  logic [NP-1:0] s_arvalid, s_arready;
  logic [15:0]   s_rid    [NP];
  logic [511:0]  s_rdata  [NP];
  logic [1:0]    s_rresp  [NP];
  logic [NP-1:0] s_rlast, s_rvalid, s_rready;
  logic [15:0]   m_arid;
  logic [63:0]   m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic          m_arvalid, m_arready;
  logic [15:0]   m_rid;
  logic [511:0]  m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast, m_rvalid, m_rready;

  axi_rd_arbiter #(.NUM_PORTS(NP), .MAX_OSTD(MO)) dut (
    .clk(clk), .reset(reset),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int          mdl_ptr;
  bit          mdl_full;
  logic [15:0] mdl_id;
  logic [63:0] mdl_addr;
  logic [7:0]  mdl_len;
  logic [2:0]  mdl_size;
  int          mdl_cnt [NP];
  int          exp_win;
  logic [NP-1:0] exp_rdy;

  // upstream requesters: a pending request is held until granted
  bit          pend   [NP];
  logic [15:0] p_id   [NP];
  logic [63:0] p_addr [NP];
  logic [7:0]  p_len  [NP];
  logic [2:0]  p_size [NP];

  task automatic arm(input int i);
    pend[i]   = 1'b1;
    p_id[i]   = 16'($urandom);
    p_addr[i] = {$urandom, $urandom};
    p_len[i]  = 8'($urandom);
    p_size[i] = 3'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      s_arvalid[i] = pend[i];
      s_arid[i]    = p_id[i];
      s_araddr[i]  = p_addr[i];
      s_arlen[i]   = p_len[i];
      s_arsize[i]  = p_size[i];
    end
  endtask

  task automatic model_reset();
    mdl_ptr = 0; mdl_full = 1'b0; mdl_id = '0; mdl_addr = '0; mdl_len = '0; mdl_size = '0;
    for (int i = 0; i < NP; i++) mdl_cnt[i] = 0;
  endtask

  task automatic model_eval();
    exp_win = -1;
    exp_rdy = '0;
    if (!reset && (!mdl_full || m_arready)) begin
      for (int k = 0; k < NP; k++) begin
        int c;
        c = (mdl_ptr + k) % NP;
        if (exp_win < 0 && pend[c] && !(OSTD_ON && mdl_cnt[c] >= MO)) exp_win = c;
      end
    end
    if (exp_win >= 0) exp_rdy[exp_win] = 1'b1;
  endtask

  task automatic model_commit();
    int rp;
    rp = int'(m_rid[15:14]);
    if (m_rvalid && m_rlast && s_rready[rp]) mdl_cnt[rp]--;
    if (exp_win >= 0) begin
      mdl_full = 1'b1;
      mdl_id   = {2'(exp_win), p_id[exp_win][13:0]};
      mdl_addr = p_addr[exp_win];
      mdl_len  = p_len[exp_win];
      mdl_size = p_size[exp_win];
      mdl_ptr  = (exp_win + 1) % NP;
      mdl_cnt[exp_win]++;
      pend[exp_win] = 1'b0;
    end else if (m_arready) begin
      mdl_full = 1'b0;
    end
  endtask

  task automatic tick_eval();
    drive();
    #1;
    model_eval();
  endtask

  task automatic tick_commit();
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NP; i++) pend[i] = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rid = '0;
    m_rdata = '0; m_rresp = '0; s_rready = '0;
    drive();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NP; i++) arm(i);
    m_arready = 1'b1; m_rvalid = 1'b1; m_rid = 16'h4001; m_rlast = 1'b1; s_rready = '1;
    drive();
    @(negedge clk); #1;
    n_tests++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got=%b want=0", m_arvalid); end
    n_tests++; if (s_arready !== '0) begin n_fail++; $display("FAIL reset_arready got=%b want=0", s_arready); end
    n_tests++; if (m_araddr !== '0 || m_arid !== '0) begin n_fail++; $display("FAIL reset_arfields got=%h/%h want=0", m_arid, m_araddr); end
    n_tests++; if (s_rvalid !== '0) begin n_fail++; $display("FAIL reset_rvalid got=%b want=0", s_rvalid); end
  endtask

  task automatic test_alternate();
    int seen[$];
    int ids[$];
    bit ret_pend = 1'b0;
    logic [15:0] ret_id = '0;
    do_reset();
    arm(0); arm(2);
    m_arready = 1'b1; s_rready = '1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      m_rvalid = ret_pend; m_rid = ret_id; m_rlast = 1'b1; m_rdata = {16{$urandom}};
      tick_eval();
      n_tests++; if (s_arready !== exp_rdy) begin n_fail++; $display("FAIL alt_arready cyc=%0d got=%b want=%b", cyc, s_arready, exp_rdy); end
      for (int i = 0; i < NP; i++) if (s_arready[i]) seen.push_back(i);
      if (m_arvalid) ids.push_back(int'(m_arid[15:14]));
      ret_pend = m_arvalid && m_arready;
      ret_id   = m_arid;
      tick_commit();
      if (!pend[0]) arm(0);
      if (!pend[2]) arm(2);
    end
    m_rvalid = 1'b0;
    n_tests++;
    if (seen.size() < 4 || ids.size() < 4) begin
      n_fail++; $display("FAIL alt_count got=%0d/%0d want>=4", seen.size(), ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        int want;
        want = (k % 2 == 0) ? 0 : 2;
        n_tests++; if (seen[k] != want) begin n_fail++; $display("FAIL alt_grant k=%0d got=%0d want=%0d", k, seen[k], want); end
        n_tests++; if (ids[k] != want) begin n_fail++; $display("FAIL alt_arid k=%0d got=%0d want=%0d", k, ids[k], want); end
      end
    end
  endtask

  task automatic test_stall();
    int pulses = 0;
    logic [63:0] addr;
    do_reset();
    arm(1);
    addr = p_addr[1];
    for (int cyc = 0; cyc < 8; cyc++) begin
      m_arready = (cyc == 6);
      tick_eval();
      n_tests++; if (s_arready !== exp_rdy) begin n_fail++; $display("FAIL stall_arready cyc=%0d got=%b want=%b", cyc, s_arready, exp_rdy); end
      if (s_arready[1]) pulses++;
      if (cyc >= 1 && cyc <= 6) begin
        n_tests++;
        if (m_arvalid !== 1'b1 || m_araddr !== addr) begin
          n_fail++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, m_arvalid, m_araddr, addr);
        end
      end
      if (cyc == 7) begin
        n_tests++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%b want=0", m_arvalid); end
      end
      tick_commit();
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL stall_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_all_ports();
    do_reset();
    for (int i = 0; i < NP; i++) arm(i);
    m_arready = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      tick_eval();
      if (cyc == 0) begin
        n_tests++; if (s_arready !== 4'b0001) begin n_fail++; $display("FAIL all_first got=%b want=0001", s_arready); end
      end
      if (cyc >= 1 && cyc <= 4) begin
        n_tests++;
        if (m_arvalid !== 1'b1 || m_arid[15:14] !== 2'(cyc - 1)) begin
          n_fail++; $display("FAIL all_issue cyc=%0d got=%b/%0d want=1/%0d", cyc, m_arvalid, m_arid[15:14], cyc - 1);
        end
      end
      if (cyc == 5) begin
        n_tests++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL all_idle got=%b want=0", m_arvalid); end
      end
      tick_commit();
    end
  endtask

  task automatic test_r_route();
    do_reset();
    s_rready = '1;
    for (int beat = 0; beat < 4; beat++) begin
      m_rvalid = 1'b1; m_rid = 16'hC005; m_rlast = (beat == 3);
      m_rdata = {16{$urandom}}; m_rresp = 2'(beat);
      tick_eval();
      n_tests++; if (s_rvalid !== 4'b1000) begin n_fail++; $display("FAIL r_valid beat=%0d got=%b want=1000", beat, s_rvalid); end
      n_tests++; if (s_rid[3] !== 16'h0005) begin n_fail++; $display("FAIL r_id beat=%0d got=%h want=0005", beat, s_rid[3]); end
      n_tests++; if (s_rlast[3] !== (beat == 3 ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL r_last beat=%0d got=%b", beat, s_rlast[3]); end
      n_tests++; if (s_rdata[3] !== m_rdata || s_rresp[3] !== 2'(beat)) begin n_fail++; $display("FAIL r_data beat=%0d resp got=%0d want=%0d", beat, s_rresp[3], beat); end
      n_tests++; if (m_rready !== 1'b1) begin n_fail++; $display("FAIL r_ready beat=%0d got=%b want=1", beat, m_rready); end
      tick_commit();
    end
    m_rlast = 1'b0; s_rready = 4'b0111;
    tick_eval();
    n_tests++; if (m_rready !== 1'b0 || s_rvalid !== 4'b1000) begin n_fail++; $display("FAIL r_backpressure got=%b/%b want=0/1000", m_rready, s_rvalid); end
    tick_commit();
    m_rvalid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int rp;
      logic [NP-1:0] exp_rv;
      for (int i = 0; i < NP; i++) if (!pend[i] && $urandom_range(0, 2) == 0) arm(i);
      m_arready = ($urandom_range(0, 3) != 0);
      rp = $urandom_range(0, NP - 1);
      m_rvalid = 1'($urandom_range(0, 1));
      m_rid    = {2'(rp), 14'($urandom)};
      m_rlast  = ($urandom_range(0, 1) == 1) && (mdl_cnt[rp] > 0);
      m_rdata  = {16{$urandom}};
      m_rresp  = 2'($urandom);
      s_rready = 4'($urandom);
      tick_eval();
      exp_rv = '0;
      if (m_rvalid) exp_rv[rp] = 1'b1;
      n_tests++; if (s_arready !== exp_rdy) begin n_fail++; $display("FAIL rnd_arready cyc=%0d got=%b want=%b", cyc, s_arready, exp_rdy); end
      n_tests++; if (m_arvalid !== mdl_full) begin n_fail++; $display("FAIL rnd_arvalid cyc=%0d got=%b want=%b", cyc, m_arvalid, mdl_full); end
      if (mdl_full) begin
        n_tests++;
        if (m_arid !== mdl_id || m_araddr !== mdl_addr || m_arlen !== mdl_len || m_arsize !== mdl_size) begin
          n_fail++; $display("FAIL rnd_arfields cyc=%0d got=%h/%h want=%h/%h", cyc, m_arid, m_araddr, mdl_id, mdl_addr);
        end
      end
      n_tests++; if (s_rvalid !== exp_rv) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d got=%b want=%b", cyc, s_rvalid, exp_rv); end
      n_tests++; if (m_rready !== s_rready[rp]) begin n_fail++; $display("FAIL rnd_rready cyc=%0d got=%b want=%b", cyc, m_rready, s_rready[rp]); end
      n_tests++;
      if (s_rid[rp] !== {2'b00, m_rid[13:0]} || s_rdata[rp] !== m_rdata || s_rresp[rp] !== m_rresp) begin
        n_fail++; $display("FAIL rnd_rpayload cyc=%0d id got=%h want=%h", cyc, s_rid[rp], {2'b00, m_rid[13:0]});
      end
      tick_commit();
    end
    m_rvalid = 1'b0;
  endtask

`ifdef AXI_RD_ARB_OSTD_LIMIT_EN
  task automatic test_ostd();
    do_reset();
    arm(0);
    m_arready = 1'b1; s_rready = '1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      m_rvalid = (cyc == 5); m_rid = 16'h0007; m_rlast = 1'b1;
      tick_eval();
      n_tests++; if (s_arready !== exp_rdy) begin n_fail++; $display("FAIL ostd_model cyc=%0d got=%b want=%b", cyc, s_arready, exp_rdy); end
      if (cyc <= 1 || cyc == 6) begin
        n_tests++; if (s_arready[0] !== 1'b1) begin n_fail++; $display("FAIL ostd_grant cyc=%0d got=0 want=1", cyc); end
      end
      if (cyc >= 2 && cyc <= 5) begin
        n_tests++; if (s_arready[0] !== 1'b0) begin n_fail++; $display("FAIL ostd_block cyc=%0d got=1 want=0", cyc); end
      end
      tick_commit();
      if (!pend[0]) arm(0);
    end
    m_rvalid = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    arm(1);
    m_arready = 1'b0;
    tick_eval(); tick_commit();
    tick_eval();
    n_tests++; if (m_arvalid !== 1'b1) begin n_fail++; $display("FAIL areset_pre got=%b want=1", m_arvalid); end
    tick_commit();
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL areset_arvalid got=%b want=0", m_arvalid); end
    n_tests++; if (m_araddr !== '0 || s_arready !== '0) begin n_fail++; $display("FAIL areset_fields got=%h/%b want=0/0", m_araddr, s_arready); end
    @(negedge clk);
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      pend[i] = 1'b0; p_id[i] = '0; p_addr[i] = '0; p_len[i] = '0; p_size[i] = '0;
    end
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rid = '0;
    m_rdata = '0; m_rresp = '0; s_rready = '0;
    model_reset();
    drive();
    test_reset();
    test_alternate();
    test_stall();
    test_all_ports();
    test_r_route();
    test_random();
`ifdef AXI_RD_ARB_OSTD_LIMIT_EN
    test_ostd();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
